fir_sample_source: RTL

- Stimulus transmitter that drives the data_in/in_valid sample stream of the FIR datapath. It is the producing end of that valid-qualified interface.
- A host preloads a sample buffer through a write port. A start pulse then plays the buffer out as a paced stream.
- After the last sample, the block appends zero-valued flush samples so the filter tail drains. It then signals done.
- Used by the word-length-optimisation benches and the on-chip test harness to feed FIR instances with identical, repeatable stimulus.

---
 rtl/fir_sample_source.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fir_sample_source.sv
// Buffered stimulus source for the FIR sample stream: preload, paced playback, zero flush, done pulse.
// Optional FIR_SRC_LOOP_EN adds a loop input that replays the buffer without flushing.
module fir_sample_source #(
  parameter int IN_INTE_WL = 4,
  parameter int IN_FRAC_WL = 8,
  parameter int DEPTH      = 64,
  parameter int GAP_WL     = 4,
  parameter int FLUSH_LEN  = 14,
  localparam int ADDR_WL   = $clog2(DEPTH),
  localparam int DW        = IN_INTE_WL + IN_FRAC_WL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_WL-1:0]   wr_addr,
  input  logic signed [DW-1:0] wr_data,
  input  logic                 start,
  input  logic [ADDR_WL:0]     num_samples,
  input  logic [GAP_WL-1:0]    gap,
  input  logic                 hold,
`ifdef FIR_SRC_LOOP_EN
  input  logic                 loop,
`endif
  output logic signed [DW-1:0] data_in,
  output logic                 in_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int FL_WL = (FLUSH_LEN > 0) ? $clog2(FLUSH_LEN + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_GAP, S_FLUSH, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [ADDR_WL-1:0]   rd_ptr, rd_nxt, rd_src, samp_rd_nxt;
  logic [ADDR_WL:0]     rem_cnt, rem_nxt, rem_src, samp_rem;
  logic [ADDR_WL:0]     n_lat, n_nxt, nl_src, sat_num;
  logic [GAP_WL-1:0]    gap_lat, gap_lat_nxt, gap_cnt, gap_cnt_nxt;
  logic [FL_WL-1:0]     flush_cnt, fl_nxt;
  logic signed [DW-1:0] data_nxt;
  logic                 valid_nxt, busy_nxt, done_nxt, loop_w;
  logic signed [DW-1:0] sample_mem [DEPTH];

`ifdef FIR_SRC_LOOP_EN
  assign loop_w = loop;
`else
  assign loop_w = 1'b0;
`endif

  assign sat_num = (num_samples > (ADDR_WL+1)'(DEPTH)) ? (ADDR_WL+1)'(DEPTH) : num_samples;

  // Buffer is deliberately outside the reset domain so its contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en && state == S_IDLE && !busy)
      sample_mem[wr_addr] <= wr_data;
  end

  function automatic state_t slot_target(input logic [ADDR_WL:0] r, input logic [FL_WL-1:0] f);
    if (r != '0)      return S_PLAY;
    else if (f != '0) return S_FLUSH;
    else              return S_DONE;
  endfunction

  function automatic state_t after_emit(input logic [GAP_WL-1:0] g, input logic [ADDR_WL:0] r,
                                        input logic [FL_WL-1:0] f);
    if (g != '0) return S_GAP;
    else         return slot_target(r, f);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rd_ptr    <= '0;
      rem_cnt   <= '0;
      n_lat     <= '0;
      gap_lat   <= '0;
      gap_cnt   <= '0;
      flush_cnt <= '0;
      data_in   <= '0;
      in_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_ptr    <= rd_nxt;
      rem_cnt   <= rem_nxt;
      n_lat     <= n_nxt;
      gap_lat   <= gap_lat_nxt;
      gap_cnt   <= gap_cnt_nxt;
      flush_cnt <= fl_nxt;
      data_in   <= data_nxt;
      in_valid  <= valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rd_nxt      = rd_ptr;
    rem_nxt     = rem_cnt;
    n_nxt       = n_lat;
    gap_lat_nxt = gap_lat;
    gap_cnt_nxt = gap_cnt;
    fl_nxt      = flush_cnt;
    data_nxt    = data_in;
    valid_nxt   = 1'b0;
    busy_nxt    = (state != S_IDLE);
    done_nxt    = 1'b0;

    // The start cycle already emits buf[0], so IDLE and PLAY share one sample-emission path.
    rd_src      = (state == S_IDLE) ? '0 : rd_ptr;
    rem_src     = (state == S_IDLE) ? sat_num : rem_cnt;
    nl_src      = (state == S_IDLE) ? sat_num : n_lat;
    samp_rd_nxt = rd_src + ADDR_WL'(1);
    samp_rem    = rem_src - (ADDR_WL+1)'(1);
    if (samp_rem == '0 && loop_w) begin
      samp_rem    = nl_src;
      samp_rd_nxt = '0;
    end

    case (state)
      S_IDLE: begin
        if (start && !busy) begin
          busy_nxt = 1'b1;
          if (sat_num == '0) begin
            done_nxt = 1'b1;
          end else begin
            n_nxt       = sat_num;
            gap_lat_nxt = gap;
            gap_cnt_nxt = gap;
            fl_nxt      = FL_WL'(FLUSH_LEN);
            data_nxt    = sample_mem[rd_src];
            valid_nxt   = 1'b1;
            rd_nxt      = samp_rd_nxt;
            rem_nxt     = samp_rem;
            state_nxt   = after_emit(gap, samp_rem, FL_WL'(FLUSH_LEN));
          end
        end
      end
      S_PLAY: begin
        if (!hold) begin
          data_nxt    = sample_mem[rd_src];
          valid_nxt   = 1'b1;
          rd_nxt      = samp_rd_nxt;
          rem_nxt     = samp_rem;
          gap_cnt_nxt = gap_lat;
          state_nxt   = after_emit(gap_lat, samp_rem, flush_cnt);
        end
      end
      S_GAP: begin
        if (!hold) begin
          if (gap_cnt <= GAP_WL'(1)) state_nxt = slot_target(rem_cnt, flush_cnt);
          else                       gap_cnt_nxt = gap_cnt - GAP_WL'(1);
        end
      end
      S_FLUSH: begin
        if (!hold) begin
          data_nxt    = '0;
          valid_nxt   = 1'b1;
          fl_nxt      = flush_cnt - FL_WL'(1);
          gap_cnt_nxt = gap_lat;
          state_nxt   = after_emit(gap_lat, rem_cnt, flush_cnt - FL_WL'(1));
        end
      end
      S_DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
